// File: rtl/spi_note_receiver.sv
// SPI mode-0 slave that turns complete WORD_BITS-bit frames into a parallel word for the playback core.
// Latency: ce pin fall to word_valid/frame_err is SYNC_STAGES+2 clk edges.
// Backpressure: none; the MCU paces frames, and short or over-length frames are dropped with a frame_err pulse.
module spi_note_receiver #(
    parameter int WORD_BITS   = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 sck,
    input  logic                 sdi,
    input  logic                 ce,
    output logic [WORD_BITS-1:0] flat_out,
    output logic                 word_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(WORD_BITS + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] ce_sync;
    logic                   p_sck;
    logic                   p_ce;
    logic [SYNC_STAGES:0]   fill;
    logic                   armed;
    logic [WORD_BITS-1:0]   shift;
    logic [CW-1:0]          count;
    logic                   overflow;
    logic                   pend_ok;
    logic                   pend_err;

    logic s_sck, s_sdi, s_ce;
    logic sck_rise, ce_rise, ce_fall;
    logic chain_ok, armed_now;

    assign s_sck    = sck_sync[SYNC_STAGES-1];
    assign s_sdi    = sdi_sync[SYNC_STAGES-1];
    assign s_ce     = ce_sync[SYNC_STAGES-1];
    assign sck_rise = s_sck & ~p_sck;
    assign ce_rise  = s_ce & ~p_ce;
    assign ce_fall  = ~s_ce & p_ce;

    // The sync chains restart at 0 after reset, so a ce already high would look like a fresh
    // rising edge. Only accept ce_rise once p_ce holds a real sample that showed ce low.
    assign chain_ok  = fill[SYNC_STAGES];
    assign armed_now = armed | (chain_ok & ~p_ce);

    always_ff @(posedge clk) begin
        if (nreset) begin
            state      <= IDLE;
            sck_sync   <= '0;
            sdi_sync   <= '0;
            ce_sync    <= '0;
            p_sck      <= 1'b0;
            p_ce       <= 1'b0;
            fill       <= '0;
            armed      <= 1'b0;
            shift      <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            pend_ok    <= 1'b0;
            pend_err   <= 1'b0;
            flat_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            ce_sync  <= {ce_sync[SYNC_STAGES-2:0], ce};
            p_sck    <= s_sck;
            p_ce     <= s_ce;
            fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
            armed    <= armed_now;

            // The frame verdict is registered one cycle before it is published; shift is
            // stable in that cycle because IDLE never shifts.
            pend_ok    <= 1'b0;
            pend_err   <= 1'b0;
            word_valid <= pend_ok;
            frame_err  <= pend_err;
            if (pend_ok) begin
                flat_out <= shift;
            end

            case (state)
                IDLE: begin
                    if (ce_rise && armed_now) begin
                        state    <= RECV;
                        busy     <= 1'b1;
                        shift    <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                RECV: begin
                    if (ce_fall) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (count == CW'(WORD_BITS) && !overflow) begin
                            pend_ok <= 1'b1;
                        end else begin
                            pend_err <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        shift <= {shift[WORD_BITS-2:0], s_sdi};
                        if (count == CW'(WORD_BITS)) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_note_receiver.sv
// Scoreboard bench for spi_note_receiver: each frame pushes its expected outcome, pulses pop and compare.
module tb_spi_note_receiver;
    localparam int W = 40;

    logic         clk    = 1'b0;
    logic         nreset = 1'b1;
    logic         sck    = 1'b0;
    logic         sdi    = 1'b0;
    logic         ce     = 1'b0;
    logic [W-1:0] flat_out;
    logic         word_valid;
    logic         frame_err;
    logic         busy;

    spi_note_receiver #(.WORD_BITS(W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .sck        (sck),
        .sdi        (sdi),
        .ce         (ce),
        .flat_out   (flat_out),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           err;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    logic [W-1:0] model_flat = '0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           fall_cyc = 0;
    int           pulse_cyc = -1;
    bit           t5_win = 1'b0;
    bit           t5_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (t5_win && busy) t5_busy = 1'b1;
        if (word_valid || frame_err) begin
            pulse_cyc = cyc;
            chk("pulse_onehot", {63'd0, word_valid & frame_err}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind_err", {63'd0, frame_err}, {63'd0, e.err});
                chk("flat_out", {24'd0, flat_out}, {24'd0, e.data});
            end
        end
    end

    task automatic shift_bits(input logic [63:0] data, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            sdi = data[i];
            sck = 1'b0;
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
        end
        sck = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] data, input int nbits, input int gap);
        exp_t x;
        @(negedge clk);
        ce = 1'b1;
        repeat (4) @(negedge clk);
        shift_bits(data, nbits - 1, 0);
        repeat (4) @(negedge clk);
        ce = 1'b0;
        fall_cyc = cyc;
        if (nbits == W) begin
            model_flat = data[W-1:0];
            x.err = 1'b0;
        end else begin
            x.err = 1'b1;
        end
        x.data = model_flat;
        sb.push_back(x);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t x;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_flat_out", {24'd0, flat_out}, 64'd0);
        chk("rst_word_valid", {63'd0, word_valid}, 64'd0);
        chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        nreset = 1'b0;
        repeat (5) @(negedge clk);

        // good frame and its latency from the ce pin fall
        pulse_cyc = -1;
        send_frame(64'h01_2345_6789, 40, 12);
        chk("latency", 64'(pulse_cyc - fall_cyc), 64'd4);

        // short and over-length frames
        send_frame(64'h12_3456_789A, 39, 12);
        send_frame(64'h1FF_FFFF_FFFE, 41, 12);

        // back-to-back frames with a two-cycle ce gap
        send_frame(64'hA5_A5A5_A5A5, 40, 1);
        send_frame(64'h5A_5A5A_5A5A, 40, 12);
        chk("b2b_drained", 64'(sb.size()), 64'd0);

        // reset in the middle of a frame, then the rest of that frame
        @(negedge clk);
        ce = 1'b1;
        repeat (4) @(negedge clk);
        shift_bits(64'hC3_C3C3_C3C3, 39, 20);
        nreset = 1'b1;
        model_flat = '0;
        @(negedge clk);
        t5_win = 1'b1;
        @(negedge clk);
        nreset = 1'b0;
        shift_bits(64'hC3_C3C3_C3C3, 19, 0);
        repeat (4) @(negedge clk);
        ce = 1'b0;
        repeat (12) @(negedge clk);
        t5_win = 1'b0;
        chk("midrst_flat_out", {24'd0, flat_out}, 64'd0);
        chk("midrst_busy_seen", {63'd0, t5_busy}, 64'd0);

        // zero-length frame, then sck activity with ce low
        @(negedge clk);
        ce = 1'b1;
        repeat (4) @(negedge clk);
        ce = 1'b0;
        x.err = 1'b1;
        x.data = model_flat;
        sb.push_back(x);
        repeat (12) @(negedge clk);
        chk("zero_len_drained", 64'(sb.size()), 64'd0);
        for (int k = 0; k < 5; k++) begin
            sdi = 1'($urandom_range(0, 1));
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("final_flat_out", {24'd0, flat_out}, {24'd0, model_flat});
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
